// File: rtl/scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scan_ctrl
// Summary  : Scan-chain controller. For each request it drives scan_en for
//            CHAIN_LEN cycles, captures the bits shifted out, and either
//            loads new chain state or recirculates the existing state.
// Optional : SCAN_CTRL_PARITY_EN adds a per-chain parity output of the snapshot.
// Revision : 1.0 - initial release
// ============================================================================
module scan_ctrl #(
  parameter int CHAIN_LEN  = 8,
  parameter int NUM_CHAINS = 1,
  parameter int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             mode,
  input  logic [NUM_CHAINS*CHAIN_LEN-1:0]  load_data,
  output logic                             scan_en,
  output logic [NUM_CHAINS-1:0]            scan_in,
  input  logic [NUM_CHAINS-1:0]            scan_out,
  output logic                             busy,
  output logic                             done,
  output logic [NUM_CHAINS*CHAIN_LEN-1:0]  snapshot,
  output logic                             snapshot_valid
`ifdef SCAN_CTRL_PARITY_EN
  ,
  output logic [NUM_CHAINS-1:0]            snap_parity
`endif
);

  localparam int             c_DATA_W = NUM_CHAINS * CHAIN_LEN;
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CHAIN_LEN - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_armed;
  logic                r_mode;
  logic [c_DATA_W-1:0] r_ldbuf;
  logic [c_DATA_W-1:0] r_snapshot;
  logic                r_snap_valid;
  logic                r_scan_en;
  logic                r_busy;
  logic                r_done;

  logic                w_accept;
  logic                w_last;
  logic                w_scan_en_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic [c_DATA_W-1:0] w_snap_shift;
  logic [c_DATA_W-1:0] w_ld_shift;

  // r_armed blocks a start that coincides with the edge releasing reset
  assign w_accept = (r_state == c_IDLE) && start && r_armed;
  assign w_last   = (r_state == c_SHIFT) && (r_cnt == c_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_accept) w_state_nxt = c_SHIFT;
      c_SHIFT: if (w_last)   w_state_nxt = c_DONE;
      c_DONE:  w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered below
  always_comb begin
    w_scan_en_nxt = (w_state_nxt == c_SHIFT);
    w_busy_nxt    = (w_state_nxt == c_SHIFT);
    w_done_nxt    = (w_state_nxt == c_DONE);
  end

  generate
    for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_chain
      if (CHAIN_LEN == 1) begin : g_len1
        assign w_snap_shift[c] = scan_out[c];
        assign w_ld_shift[c]   = 1'b0;
      end else begin : g_lenn
        assign w_snap_shift[c*CHAIN_LEN +: CHAIN_LEN] =
          {scan_out[c], r_snapshot[c*CHAIN_LEN+1 +: CHAIN_LEN-1]};
        assign w_ld_shift[c*CHAIN_LEN +: CHAIN_LEN] =
          {1'b0, r_ldbuf[c*CHAIN_LEN+1 +: CHAIN_LEN-1]};
      end
      assign scan_in[c] = r_scan_en & (r_mode ? scan_out[c] : r_ldbuf[c*CHAIN_LEN]);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_armed      <= 1'b0;
      r_mode       <= 1'b0;
      r_ldbuf      <= '0;
      r_snapshot   <= '0;
      r_snap_valid <= 1'b0;
      r_scan_en    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_armed   <= 1'b1;
      r_scan_en <= w_scan_en_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      if (w_accept) begin
        r_mode       <= mode;
        r_ldbuf      <= load_data;
        r_snap_valid <= 1'b0;
        r_cnt        <= '0;
      end else if (r_state == c_SHIFT) begin
        r_snapshot <= w_snap_shift;
        r_ldbuf    <= w_ld_shift;
        // Return to zero on the last shift so CHAIN_LEN=1 never wraps
        r_cnt      <= w_last ? '0 : r_cnt + 1'b1;
        if (w_last) r_snap_valid <= 1'b1;
      end
    end
  end

`ifdef SCAN_CTRL_PARITY_EN
  logic [NUM_CHAINS-1:0] r_parity;
  logic [NUM_CHAINS-1:0] w_parity_nxt;

  generate
    for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_parity
      assign w_parity_nxt[c] = ^w_snap_shift[c*CHAIN_LEN +: CHAIN_LEN];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity <= '0;
    end else if (w_last) begin
      r_parity <= w_parity_nxt;
    end
  end

  assign snap_parity = r_parity;
`endif

  assign scan_en        = r_scan_en;
  assign busy           = r_busy;
  assign done           = r_done;
  assign snapshot       = r_snapshot;
  assign snapshot_valid = r_snap_valid;

endmodule
`default_nettype wire
